// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector: compares the last N sampled bits with a
// run-time loadable pattern, emits a registered match pulse and counts matches.
module seq_detect_param #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1101,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8,
    localparam int          FILL_W  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              X,
    input  logic              load,
    input  logic [N-1:0]      pattern_in,
    input  logic              clr,
    output logic              Y,
    output logic [CNT_W-1:0]  match_count,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

    logic [N-1:0]      pat_q, pat_d;
    logic [N-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]      next_hist;
    logic              match;

    assign next_hist = {hist_q[N-2:0], X};

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = 1'b0;
        cnt_d  = cnt_q;
        match  = 1'b0;

        if (load) begin
            pat_d  = pattern_in;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = next_hist;
            // hist bits older than fill are stale, so only a full window may match
            match  = (fill_q >= FILL_LAST) && (next_hist == pat_q);
            y_d    = match;
            if (match && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Y           = y_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap, no-overlap, 2-bit counter
// with pattern 1111) share one stimulus stream and are checked against a bit-level model.
module tb_seq_detect_param;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       x_in;
    logic       load;
    logic [3:0] pattern_in;
    logic       clr;

    logic       y_o[3];
    logic [7:0] cnt_o[3];
    logic [2:0] fill_o[3];
    logic [1:0] cnt_c;

    int checks   = 0;
    int failures = 0;

    // reference model state, one slot per instance
    int rst_pat[3] = '{13, 13, 15};
    int ovl[3]     = '{1, 0, 1};
    int cmax[3]    = '{255, 255, 3};
    int m_pat[3];
    int m_hist[3];
    int m_fill[3];
    int m_y[3];
    int m_cnt[3];

    seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .X(x_in), .load(load),
        .pattern_in(pattern_in), .clr(clr),
        .Y(y_o[0]), .match_count(cnt_o[0]), .fill(fill_o[0])
    );

    seq_detect_param #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .X(x_in), .load(load),
        .pattern_in(pattern_in), .clr(clr),
        .Y(y_o[1]), .match_count(cnt_o[1]), .fill(fill_o[1])
    );

    seq_detect_param #(.N(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .X(x_in), .load(load),
        .pattern_in(pattern_in), .clr(clr),
        .Y(y_o[2]), .match_count(cnt_c), .fill(fill_o[2])
    );

    assign cnt_o[2] = {6'b0, cnt_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update(input logic r, input logic l, input logic e,
                                input logic xb, input logic [3:0] p, input logic c);
        int hit;
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                m_pat[i]  = rst_pat[i];
                m_hist[i] = 0;
                m_fill[i] = 0;
                m_y[i]    = 0;
                m_cnt[i]  = 0;
            end else begin
                hit = 0;
                if (l) begin
                    m_pat[i]  = int'(p);
                    m_hist[i] = 0;
                    m_fill[i] = 0;
                    m_y[i]    = 0;
                end else if (e) begin
                    m_hist[i] = (m_hist[i] * 2 + int'(xb)) % 16;
                    hit       = ((m_fill[i] + 1 >= 4) && (m_hist[i] == m_pat[i])) ? 1 : 0;
                    m_y[i]    = hit;
                    if (hit != 0 && ovl[i] == 0) m_fill[i] = 0;
                    else m_fill[i] = (m_fill[i] + 1 > 4) ? 4 : m_fill[i] + 1;
                end else begin
                    m_y[i] = 0;
                end
                if (c) m_cnt[i] = 0;
                else if (hit != 0 && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic xb,
                         input logic [3:0] p, input logic c);
        rst_n = r; load = l; en = e; x_in = xb; pattern_in = p; clr = c;
        @(posedge clk);
        model_update(r, l, e, xb, p, c);
        #1;
    endtask

    task automatic send(input logic xb);
        drive(1'b1, 1'b0, 1'b1, xb, 4'b0000, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        for (int k = 0; k < cycles; k++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset;
        do_reset(2);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (y_o[i] !== 1'b0 || cnt_o[i] !== 8'd0 || fill_o[i] !== 3'd0) begin
                    failures++;
                    $display("FAIL reset_idle inst%0d cyc%0d got y=%0b cnt=%0d fill=%0d exp 0/0/0",
                             i, k, y_o[i], cnt_o[i], fill_o[i]);
                end
            end
        end
    endtask

    task automatic test_overlap;
        logic [6:0] stream;
        logic [6:0] exp_y;
        stream = 7'b1101101;
        exp_y  = 7'b0001001;
        do_reset(1);
        for (int k = 0; k < 7; k++) begin
            send(stream[6-k]);
            checks++;
            if (y_o[0] !== exp_y[6-k]) begin
                failures++;
                $display("FAIL overlap_y bit%0d got %0b exp %0b", k + 1, y_o[0], exp_y[6-k]);
            end
        end
        checks++;
        if (cnt_o[0] !== 8'd2 || fill_o[0] !== 3'd4) begin
            failures++;
            $display("FAIL overlap_cnt got cnt=%0d fill=%0d exp cnt=2 fill=4", cnt_o[0], fill_o[0]);
        end
    endtask

    task automatic test_no_overlap;
        logic [6:0] stream;
        logic [6:0] exp_y;
        int         exp_fill[7];
        stream   = 7'b1101101;
        exp_y    = 7'b0001000;
        exp_fill = '{1, 2, 3, 0, 1, 2, 3};
        do_reset(1);
        for (int k = 0; k < 7; k++) begin
            send(stream[6-k]);
            checks++;
            if (y_o[1] !== exp_y[6-k] || fill_o[1] !== 3'(exp_fill[k])) begin
                failures++;
                $display("FAIL no_overlap bit%0d got y=%0b fill=%0d exp y=%0b fill=%0d",
                         k + 1, y_o[1], fill_o[1], exp_y[6-k], exp_fill[k]);
            end
        end
        checks++;
        if (cnt_o[1] !== 8'd1) begin
            failures++;
            $display("FAIL no_overlap_cnt got %0d exp 1", cnt_o[1]);
        end
    endtask

    task automatic test_gaps_load;
        do_reset(1);
        send(1'b1); send(1'b1); send(1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        send(1'b1);
        checks++;
        if (y_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL gap_match got y=%0b exp 1", y_o[0]);
        end
        send(1'b1); send(1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0);
        checks++;
        if (y_o[0] !== 1'b0 || fill_o[0] !== 3'd0) begin
            failures++;
            $display("FAIL load_clear got y=%0b fill=%0d exp y=0 fill=0", y_o[0], fill_o[0]);
        end
        for (int k = 0; k < 4; k++) begin
            send((k == 1 || k == 2) ? 1'b1 : 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (y_o[i] !== 1'(m_y[i]) || y_o[i] !== ((k == 3) ? 1'b1 : 1'b0)) begin
                    failures++;
                    $display("FAIL load_seq inst%0d bit%0d got y=%0b exp %0b",
                             i, k + 1, y_o[i], (k == 3));
                end
            end
        end
    endtask

    task automatic test_saturation_clr;
        int         seen_c;
        logic [7:0] exp_cnt[3];
        exp_cnt = '{8'd5, 8'd2, 8'd3};
        seen_c  = 0;
        do_reset(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0);
        for (int k = 0; k < 8; k++) begin
            send(1'b1);
            if (y_o[2] === 1'b1) seen_c++;
        end
        checks++;
        if (seen_c != 5) begin
            failures++;
            $display("FAIL sat_pulses got %0d exp 5", seen_c);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cnt_o[i] !== exp_cnt[i]) begin
                failures++;
                $display("FAIL sat_cnt inst%0d got %0d exp %0d", i, cnt_o[i], exp_cnt[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1);
        checks++;
        if (y_o[2] !== 1'b1 || cnt_o[2] !== 8'd0 || cnt_o[0] !== 8'd0) begin
            failures++;
            $display("FAIL clr_vs_match got y=%0b cnt_c=%0d cnt_a=%0d exp y=1 cnt=0",
                     y_o[2], cnt_o[2], cnt_o[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [2:0] tail;
        do_reset(1);
        send(1'b1); send(1'b1); send(1'b0);
        do_reset(1);
        send(1'b1);
        checks++;
        if (y_o[0] !== 1'b0 || fill_o[0] !== 3'd1) begin
            failures++;
            $display("FAIL reset_mid got y=%0b fill=%0d exp y=0 fill=1", y_o[0], fill_o[0]);
        end
        tail = 3'b101;
        for (int k = 0; k < 3; k++) send(tail[2-k]);
        checks++;
        if (y_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_pattern got y=%0b exp 1 (pattern 1101 restored)", y_o[0]);
        end
    endtask

    task automatic test_random;
        logic       r, l, e, xb, c;
        logic [3:0] p;
        do_reset(1);
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(0, 99) != 0);
            l  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            xb = ($urandom_range(0, 2) != 0);
            p  = 4'($urandom_range(0, 15));
            c  = ($urandom_range(0, 49) == 0);
            drive(r, l, e, xb, p, c);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (y_o[i] !== 1'(m_y[i]) || cnt_o[i] !== 8'(m_cnt[i]) ||
                    fill_o[i] !== 3'(m_fill[i])) begin
                    failures++;
                    $display("FAIL random inst%0d cyc%0d got y=%0b cnt=%0d fill=%0d exp y=%0d cnt=%0d fill=%0d",
                             i, k, y_o[i], cnt_o[i], fill_o[i], m_y[i], m_cnt[i], m_fill[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; x_in = 1'b0; load = 1'b0; pattern_in = 4'b0000; clr = 1'b0;
        test_reset;
        test_overlap;
        test_no_overlap;
        test_gaps_load;
        test_saturation_clr;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector. It samples one input bit per enabled clock and compares the last `N` bits against a pattern. The pattern is loadable at run time. It emits a one-cycle registered `Y` pulse on each match and keeps a saturating match counter. It is the generalised successor of the fixed-pattern single-bit detector FSMs in the project: pattern length, pattern value, overlap policy and counter width are all configurable.

## Interface
Parameters:
- `N`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1101: pattern loaded at reset; `N` bits wide; MSB is the oldest bit, LSB the newest.
- `OVERLAP`, 1: 1 lets matches share bits; 0 restarts detection after each match.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: sample enable; `X` is consumed only when `en=1`.
- `X`, in, 1: serial data bit.
- `load`, in, 1: strobe that replaces the pattern with `pattern_in`.
- `pattern_in`, in, N: new pattern; same bit order as `PATTERN`.
- `clr`, in, 1: clears `match_count`.
- `Y`, out, 1: registered match pulse.
- `match_count`, out, CNT_W: number of matches, saturating.
- `fill`, out, clog2(N+1): number of valid history bits, 0..N.

## Operation
- State registers: `pat_reg[N-1:0]`, `hist[N-1:0]`, `fill`, `Y`, `match_count`.
- Reset (`rst_n=0` at an edge): `pat_reg=PATTERN`, `hist=0`, `fill=0`, `Y=0`, `match_count=0`. Reset overrides every other input.
- Priority on each edge with `rst_n=1`: `load` > `en`. `clr` is handled independently of both.
- `load=1`:
  - `pat_reg<=pattern_in`, `hist<=0`, `fill<=0`, `Y<=0`.
  - `X` is ignored that cycle, even if `en=1`.
- `load=0`, `en=1`:
  - `nh={hist[N-2:0],X}`; `hist<=nh`.
  - `match=(fill>=N-1) && (nh==pat_reg)`; `Y<=match`.
  - `fill<=min(fill+1,N)`, except that a match with `OVERLAP=0` sets `fill<=0`.
  - The `hist` contents are don't-care whenever `fill<N`, because matching is gated by `fill`.
- `load=0`, `en=0`: `Y<=0`; `hist`, `fill` and `pat_reg` hold.
- `match_count`:
  - Increments by 1 on each match and saturates at 2^CNT_W-1.
  - `clr=1` forces it to 0. `clr` wins over a simultaneous match.
- Matches depend only on the bit stream. Gaps in `en` do not break a partial sequence.
- A `load` in the middle of a sequence discards the partial history. No match can occur until `N` new bits have been sampled.

## Timing
- Latency: `Y` is high in the cycle after the edge that sampled the completing bit, and for exactly one cycle.
- Back-to-back matches:
  - With `OVERLAP=1`, a match can occur on consecutive enabled samples when the pattern allows it, e.g. all-ones.
  - With `OVERLAP=0`, the minimum spacing between matches is `N` enabled samples.
- `match_count` updates on the same edge that sets `Y`.
- `fill` updates on every enabled sample.
- A new `pat_reg` from `load` applies to the first sample after the load edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
1. Reset and idle: hold `rst_n=0` for 2 cycles, then release with `en=0` -> `Y=0`, `match_count=0`, `fill=0`, and all three stay there.
2. Overlap match: defaults (`OVERLAP=1`, pattern 1101), `en=1`, `X`=1,1,0,1,1,0,1 -> `Y` pulses the cycle after bit 4 and the cycle after bit 7; `match_count=2`.
3. No-overlap: `OVERLAP=0`, same stream -> single `Y` pulse after bit 4; `fill` shows 0 after that match and 3 after bit 7; `match_count=1`.
4. Gaps and load:
   - Send 1,1,0, then 3 cycles with `en=0`, then 1 -> `Y` pulses after the final 1.
   - Then assert `load` with `pattern_in`=0110 in the middle of a sequence, and send 0,1,1,0 -> exactly one `Y` pulse, after the last 0.
5. Saturation and `clr`:
   - `CNT_W=2`, pattern 1111, `OVERLAP=1`, feed 8 ones -> 5 matches seen, `match_count` holds at 3.
   - Assert `clr` on the same cycle as a match -> `match_count=0` and `Y` still pulses.
6. Reset mid-operation: after 3 pattern bits, assert `rst_n=0` for 1 edge, then send the 4th bit -> no `Y`; `fill=1` after that bit; `pat_reg` restored to `PATTERN`.
